// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with a 2-bit saturating counter per entry.
//   Lookup (IF):  if_pc -> pred_taken, pred_target, bp_stat (combinational).
//   Resolve (MEM): upd_en, mem_pc, mem_target, mem_pcsrc, zero, mem_pred_taken,
//                  mem_pred_target -> mispredict (combinational); trains table on CLK.
//   Stats:        br_cnt / mis_cnt, built only when BP_STATS_EN is defined,
//                 otherwise tied to zero.
//   Clock/reset:  CLK, RST (synchronous, active-high).

package branch_predictor_pkg;
    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } branch_pred_state_t;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'b00,
        PC_BEQ   = 2'b01,
        PC_BNE   = 2'b10,
        PC_JUMP  = 2'b11
    } pcsrc_t;
endpackage

module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [31:0]        if_pc,
    output logic               pred_taken,
    output logic [31:0]        pred_target,
    output branch_pred_state_t bp_stat,
    input  logic               upd_en,
    input  logic [31:0]        mem_pc,
    input  logic [31:0]        mem_target,
    input  pcsrc_t             mem_pcsrc,
    input  logic               zero,
    input  logic               mem_pred_taken,
    input  logic [31:0]        mem_pred_target,
    output logic               mispredict,
    output logic [31:0]        br_cnt,
    output logic [31:0]        mis_cnt
);
    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q, valid_d;
    branch_pred_state_t ctr_q    [ENTRIES];
    branch_pred_state_t ctr_d    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];

    logic [IDX_W-1:0]   lk_idx;
    logic               lk_hit;
    branch_pred_state_t lk_ctr;
    logic [IDX_W-1:0]   up_idx;
    logic [TAG_W-1:0]   up_tag;
    logic               up_hit;
    logic               actual_taken;

    // Word-aligned PCs: the two low bits never select anything.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], mem_pc[1:0]};

    // Lookup against registered contents only (no bypass of a same-cycle write).
    always_comb begin
        lk_idx      = if_pc[IDX_W+1:2];
        lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == if_pc[31:IDX_W+2]);
        lk_ctr      = ctr_q[lk_idx];
        pred_taken  = lk_hit && lk_ctr[1];
        pred_target = pred_taken ? target_q[lk_idx] : (if_pc + 32'd4);
        bp_stat     = lk_hit ? lk_ctr : WEAK_NT;
    end

    // Resolution: a taken branch also mispredicts if it went somewhere else.
    always_comb begin
        actual_taken = (mem_pcsrc == PC_BNE) ? ~zero : zero;
        mispredict   = upd_en && ((actual_taken != mem_pred_taken) ||
                                  (actual_taken && (mem_target != mem_pred_target)));
    end

    // Training: hit -> saturating count (+target on taken); taken miss -> allocate.
    always_comb begin
        valid_d  = valid_q;
        ctr_d    = ctr_q;
        tag_d    = tag_q;
        target_d = target_q;
        up_idx   = mem_pc[IDX_W+1:2];
        up_tag   = mem_pc[31:IDX_W+2];
        up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        if (upd_en) begin
            if (up_hit) begin
                if (actual_taken) begin
                    ctr_d[up_idx]    = (ctr_q[up_idx] == STRONG_T) ? STRONG_T :
                                       branch_pred_state_t'(2'(ctr_q[up_idx]) + 2'd1);
                    target_d[up_idx] = mem_target;
                end else begin
                    ctr_d[up_idx]    = (ctr_q[up_idx] == STRONG_NT) ? STRONG_NT :
                                       branch_pred_state_t'(2'(ctr_q[up_idx]) - 2'd1);
                end
            end else if (actual_taken) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = mem_target;
                ctr_d[up_idx]    = WEAK_T;
            end
        end
    end

    // Valid and counters reset; reset overrides any concurrent update.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= WEAK_NT;
            end
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
        end
    end

    // Tag/target are qualified by valid, so they carry no reset.
    always_ff @(posedge CLK) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

`ifdef BP_STATS_EN
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] mis_cnt_q, mis_cnt_d;

    // Free-running statistics, wrap modulo 2^32.
    always_comb begin
        br_cnt_d  = br_cnt_q + 32'(upd_en);
        mis_cnt_d = mis_cnt_q + 32'(mispredict);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign br_cnt  = br_cnt_q;
    assign mis_cnt = mis_cnt_q;
`else
    assign br_cnt  = '0;
    assign mis_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor (ENTRIES = 16).
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic [31:0]        if_pc = '0;
    logic               pred_taken;
    logic [31:0]        pred_target;
    branch_pred_state_t bp_stat;
    logic               upd_en = 1'b0;
    logic [31:0]        mem_pc = '0;
    logic [31:0]        mem_target = '0;
    pcsrc_t             mem_pcsrc = PC_BEQ;
    logic               zero = 1'b0;
    logic               mem_pred_taken = 1'b0;
    logic [31:0]        mem_pred_target = '0;
    logic               mispredict;
    logic [31:0]        br_cnt;
    logic [31:0]        mis_cnt;

    int n_cmp = 0;
    int n_err = 0;

    branch_predictor #(.ENTRIES(16)) dut (
        .CLK(CLK), .RST(RST), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target), .bp_stat(bp_stat),
        .upd_en(upd_en), .mem_pc(mem_pc), .mem_target(mem_target),
        .mem_pcsrc(mem_pcsrc), .zero(zero), .mem_pred_taken(mem_pred_taken),
        .mem_pred_target(mem_pred_target), .mispredict(mispredict),
        .br_cnt(br_cnt), .mis_cnt(mis_cnt)
    );

    always #5 CLK = ~CLK;

    // Inputs change at the falling edge; checks run 1 time unit later.
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic set_upd(input logic en, input logic [31:0] pc, input logic [31:0] tgt,
                           input pcsrc_t src, input logic z, input logic pt,
                           input logic [31:0] ptgt);
        upd_en = en; mem_pc = pc; mem_target = tgt; mem_pcsrc = src;
        zero = z; mem_pred_taken = pt; mem_pred_target = ptgt;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        if_pc = 32'h40;
        set_upd(1'b0, 32'h0, 32'h0, PC_BEQ, 1'b0, 1'b0, 32'h0);
        #1;
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL cold_pred_taken got %0b exp 0", pred_taken); end
        n_cmp++; if (pred_target !== 32'h44) begin n_err++; $display("FAIL cold_pred_target got %h exp 00000044", pred_target); end
        n_cmp++; if (bp_stat !== WEAK_NT) begin n_err++; $display("FAIL cold_bp_stat got %b exp 01", bp_stat); end
        n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL idle_mispredict got %0b exp 0", mispredict); end
        n_cmp++; if (br_cnt !== 32'd0 || mis_cnt !== 32'd0) begin n_err++; $display("FAIL reset_stats got %0d/%0d exp 0/0", br_cnt, mis_cnt); end
        // BNE with zero=0 resolves taken; flushed prediction says not taken.
        set_upd(1'b1, 32'h40, 32'h80, PC_BNE, 1'b0, 1'b0, 32'h0);
        #1;
        n_cmp++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL bne_taken_mispredict got %0b exp 1", mispredict); end
        upd_en = 1'b0;
        #1;
        n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL gated_mispredict got %0b exp 0", mispredict); end
    endtask

    task automatic test_allocate();
        if_pc = 32'h40;
        set_upd(1'b1, 32'h40, 32'h80, PC_BEQ, 1'b1, 1'b0, 32'h0);
        #1;
        n_cmp++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL alloc_mispredict got %0b exp 1", mispredict); end
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL alloc_same_cycle_pred got %0b exp 0", pred_taken); end
        step();
        upd_en = 1'b0;
        #1;
        n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL alloc_pred_taken got %0b exp 1", pred_taken); end
        n_cmp++; if (pred_target !== 32'h80) begin n_err++; $display("FAIL alloc_pred_target got %h exp 00000080", pred_target); end
        n_cmp++; if (bp_stat !== WEAK_T) begin n_err++; $display("FAIL alloc_bp_stat got %b exp 10", bp_stat); end
    endtask

    task automatic test_saturation();
        if_pc = 32'h40;
        for (int i = 0; i < 3; i++) begin
            set_upd(1'b1, 32'h40, 32'h80, PC_BEQ, 1'b1, 1'b1, 32'h80);
            #1;
            n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL sat_up%0d_mispredict got %0b exp 0", i, mispredict); end
            step();
            upd_en = 1'b0;
            #1;
            n_cmp++; if (bp_stat !== STRONG_T) begin n_err++; $display("FAIL sat_up%0d_bp_stat got %b exp 11", i, bp_stat); end
        end
        // First not-taken: hysteresis keeps predicting taken.
        set_upd(1'b1, 32'h40, 32'h80, PC_BNE, 1'b1, 1'b1, 32'h80);
        #1;
        n_cmp++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL nt1_mispredict got %0b exp 1", mispredict); end
        step();
        upd_en = 1'b0;
        #1;
        n_cmp++; if (bp_stat !== WEAK_T || pred_taken !== 1'b1 || pred_target !== 32'h80) begin
            n_err++; $display("FAIL nt1_state got %b/%0b/%h exp 10/1/00000080", bp_stat, pred_taken, pred_target); end
        set_upd(1'b1, 32'h40, 32'h80, PC_BNE, 1'b1, 1'b1, 32'h80);
        step();
        upd_en = 1'b0;
        #1;
        n_cmp++; if (bp_stat !== WEAK_NT || pred_taken !== 1'b0 || pred_target !== 32'h44) begin
            n_err++; $display("FAIL nt2_state got %b/%0b/%h exp 01/0/00000044", bp_stat, pred_taken, pred_target); end
        for (int i = 0; i < 2; i++) begin
            set_upd(1'b1, 32'h40, 32'h80, PC_BNE, 1'b1, 1'b0, 32'h0);
            #1;
            n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL nt_low%0d_mispredict got %0b exp 0", i, mispredict); end
            step();
            upd_en = 1'b0;
            #1;
            n_cmp++; if (bp_stat !== STRONG_NT) begin n_err++; $display("FAIL nt_low%0d_bp_stat got %b exp 00", i, bp_stat); end
        end
        // Taken on a hit increments from STRONG_NT (no reallocation to WEAK_T).
        set_upd(1'b1, 32'h40, 32'h84, PC_BEQ, 1'b1, 1'b0, 32'h0);
        step();
        upd_en = 1'b0;
        #1;
        n_cmp++; if (bp_stat !== WEAK_NT || pred_taken !== 1'b0 || pred_target !== 32'h44) begin
            n_err++; $display("FAIL hit_inc1 got %b/%0b/%h exp 01/0/00000044", bp_stat, pred_taken, pred_target); end
        set_upd(1'b1, 32'h40, 32'h84, PC_BEQ, 1'b1, 1'b0, 32'h0);
        step();
        upd_en = 1'b0;
        #1;
        n_cmp++; if (bp_stat !== WEAK_T || pred_target !== 32'h84) begin
            n_err++; $display("FAIL hit_inc2 got %b/%h exp 10/00000084", bp_stat, pred_target); end
    endtask

    task automatic test_alias();
        set_upd(1'b1, 32'h440, 32'h100, PC_BEQ, 1'b1, 1'b0, 32'h0);
        step();
        upd_en = 1'b0;
        if_pc = 32'h40;
        #1;
        n_cmp++; if (bp_stat !== WEAK_NT || pred_taken !== 1'b0 || pred_target !== 32'h44) begin
            n_err++; $display("FAIL alias_old_miss got %b/%0b/%h exp 01/0/00000044", bp_stat, pred_taken, pred_target); end
        if_pc = 32'h440;
        #1;
        n_cmp++; if (bp_stat !== WEAK_T || pred_target !== 32'h100) begin
            n_err++; $display("FAIL alias_new_hit got %b/%h exp 10/00000100", bp_stat, pred_target); end
        set_upd(1'b1, 32'h440, 32'h90, PC_BEQ, 1'b1, 1'b1, 32'h80);
        #1;
        n_cmp++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL target_mismatch got %0b exp 1", mispredict); end
        step();
        upd_en = 1'b0;
        #1;
        n_cmp++; if (bp_stat !== STRONG_T || pred_target !== 32'h90) begin
            n_err++; $display("FAIL target_retrain got %b/%h exp 11/00000090", bp_stat, pred_target); end
        // Not-taken resolution ignores target disagreement.
        set_upd(1'b1, 32'h440, 32'h90, PC_BNE, 1'b1, 1'b0, 32'h80);
        #1;
        n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL nt_target_ignored got %0b exp 0", mispredict); end
        upd_en = 1'b0;
        // Not-taken miss must not allocate.
        set_upd(1'b1, 32'h48, 32'h300, PC_BEQ, 1'b0, 1'b0, 32'h0);
        step();
        upd_en = 1'b0;
        if_pc = 32'h48;
        #1;
        n_cmp++; if (bp_stat !== WEAK_NT || pred_target !== 32'h4C) begin
            n_err++; $display("FAIL nt_miss_no_alloc got %b/%h exp 01/0000004c", bp_stat, pred_target); end
        // Table holds with upd_en low.
        set_upd(1'b0, 32'h48, 32'h300, PC_BEQ, 1'b1, 1'b0, 32'h0);
        step();
        #1;
        n_cmp++; if (pred_taken !== 1'b0 || bp_stat !== WEAK_NT) begin
            n_err++; $display("FAIL idle_hold got %0b/%b exp 0/01", pred_taken, bp_stat); end
    endtask

    task automatic test_same_cycle();
        if_pc = 32'h440;
        set_upd(1'b1, 32'h440, 32'h90, PC_BNE, 1'b1, 1'b1, 32'h90);
        #1;
        n_cmp++; if (bp_stat !== STRONG_T || pred_taken !== 1'b1 || pred_target !== 32'h90) begin
            n_err++; $display("FAIL same_cycle_old got %b/%0b/%h exp 11/1/00000090", bp_stat, pred_taken, pred_target); end
        step();
        upd_en = 1'b0;
        #1;
        n_cmp++; if (bp_stat !== WEAK_T) begin n_err++; $display("FAIL same_cycle_new got %b exp 10", bp_stat); end
    endtask

    task automatic test_reset_mid();
        set_upd(1'b1, 32'h50, 32'h500, PC_BEQ, 1'b1, 1'b0, 32'h0);
        RST = 1'b1;
        step();
        RST = 1'b0;
        upd_en = 1'b0;
        if_pc = 32'h50;
        #1;
        n_cmp++; if (pred_taken !== 1'b0 || bp_stat !== WEAK_NT) begin
            n_err++; $display("FAIL reset_discards_upd got %0b/%b exp 0/01", pred_taken, bp_stat); end
        if_pc = 32'h440;
        #1;
        n_cmp++; if (bp_stat !== WEAK_NT || pred_target !== 32'h444) begin
            n_err++; $display("FAIL reset_clears_valid got %b/%h exp 01/00000444", bp_stat, pred_target); end
    endtask

    task automatic test_stats();
        pcsrc_t      src [5] = '{PC_BEQ, PC_BEQ, PC_BEQ, PC_BNE, PC_BNE};
        logic        pt  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic        exp_mis [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] exp_br;
        logic [31:0] exp_mc;
`ifdef BP_STATS_EN
        exp_br = 32'd5; exp_mc = 32'd2;
`else
        exp_br = 32'd0; exp_mc = 32'd0;
`endif
        for (int i = 0; i < 5; i++) begin
            set_upd(1'b1, 32'h60, 32'h200, src[i], 1'b1, pt[i], 32'h200);
            #1;
            n_cmp++; if (mispredict !== exp_mis[i]) begin n_err++; $display("FAIL stats_upd%0d_mispredict got %0b exp %0b", i, mispredict, exp_mis[i]); end
            step();
        end
        upd_en = 1'b0;
        #1;
        n_cmp++; if (br_cnt !== exp_br) begin n_err++; $display("FAIL br_cnt got %0d exp %0d", br_cnt, exp_br); end
        n_cmp++; if (mis_cnt !== exp_mc) begin n_err++; $display("FAIL mis_cnt got %0d exp %0d", mis_cnt, exp_mc); end
        RST = 1'b1;
        step();
        RST = 1'b0;
        #1;
        n_cmp++; if (br_cnt !== 32'd0 || mis_cnt !== 32'd0) begin
            n_err++; $display("FAIL stats_reset got %0d/%0d exp 0/0", br_cnt, mis_cnt); end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_saturation();
        test_alias();
        test_same_cycle();
        test_reset_mid();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the pipelined datapath: a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry. In IF it predicts the next PC. In MEM it is trained by the resolved branch and flags mispredictions. It produces `bp_stat` and `mispredict`, which `hazard_unit` consumes to drive `pcen` and the pipeline flushes.

## Interface
Parameters:
- `ENTRIES`, 16 — BTB depth; power of two, 4..64.
- `IDX_W`, `$clog2(ENTRIES)` — index width. Index = `pc[IDX_W+1:2]`; tag = `pc[31:IDX_W+2]`.

Ports:
- `CLK` — in, 1, the single clock.
- `RST` — in, 1, reset; synchronous, active-high.
- `if_pc` — in, 32, fetch PC being looked up.
- `pred_taken` — out, 1, predict taken for `if_pc`.
- `pred_target` — out, 32, predicted next PC.
- `bp_stat` — out, `branch_pred_state_t`, counter state of the looked-up entry.
- `upd_en` — in, 1, a resolved conditional branch is in MEM and EX/MEM is advancing.
- `mem_pc` — in, 32, PC of the resolved branch.
- `mem_target` — in, 32, computed branch target.
- `mem_pcsrc` — in, `pcsrc_t`, branch kind; `PC_BEQ` or `PC_BNE`.
- `zero` — in, 1, ALU zero flag of the branch compare.
- `mem_pred_taken` — in, 1, prediction made in IF, carried down the pipeline.
- `mem_pred_target` — in, 32, predicted target, carried down the pipeline.
- `mispredict` — out, 1, resolution disagrees with the prediction.
- `br_cnt` — out, 32, resolved-branch count (statistics).
- `mis_cnt` — out, 32, misprediction count (statistics).

## Operation
Storage per entry: `valid` (1 bit), `tag`, `target` (32 bits) and `ctr` (`branch_pred_state_t`).

Counter encoding:
- `STRONG_NT` = 00, `WEAK_NT` = 01, `WEAK_T` = 10, `STRONG_T` = 11.
- Taken is predicted when `ctr[1]` = 1.

Lookup (combinational from `if_pc` and the registered table):
- A hit is `valid` set and the tag matching.
- `pred_taken` = hit && `ctr[1]`.
- `pred_target` = the entry's `target` when `pred_taken`, else `if_pc + 4` (32-bit, wraps).
- `bp_stat` = the entry's `ctr` on a hit, else `WEAK_NT`.

Resolution (combinational):
- `actual_taken` = `zero` for `PC_BEQ`, `~zero` for `PC_BNE`.
- `mispredict` = `upd_en` && ((`actual_taken` != `mem_pred_taken`) || (`actual_taken` && `mem_target` != `mem_pred_target`)).
- `mispredict` is 0 whenever `upd_en` = 0.

Training (on the rising edge of `CLK` when `upd_en` = 1; entry indexed by `mem_pc`):
- Tag hit: saturating increment of `ctr` if taken, saturating decrement if not taken. If taken, also write `target` = `mem_target`.
- Miss and taken: allocate the entry. Set `valid` = 1, tag, `target` = `mem_target`, `ctr` = `WEAK_T`. Any previous occupant is replaced.
- Miss and not taken: no change to the table.
- `upd_en` = 0: the table holds.

## Timing
- Prediction has zero-cycle latency (same cycle as `if_pc`). A training write is visible to lookups from the next cycle.
- Lookup and update to the same index in the same cycle: the lookup sees the pre-update contents. There is no write-through bypass.
- `RST` asserted on a clock edge clears every `valid` bit, sets every `ctr` to `WEAK_NT` and zeroes both statistics counters. This takes effect even in the middle of training; an `upd_en` in the reset cycle is discarded.
- Output values immediately after reset:
  - `pred_taken` = 0;
  - `pred_target` = `if_pc + 4`;
  - `bp_stat` = `WEAK_NT`;
  - `mispredict` = `upd_en` && `actual_taken` (combinational; `mem_pred_*` come from the flushed pipeline as 0).
- Counters saturate at `STRONG_T` and `STRONG_NT`; they never wrap.
- Tag and target storage need no reset; they are qualified by `valid`.

## Configuration
- `BP_STATS_EN` defined:
  - `br_cnt` increments on every cycle with `upd_en` = 1.
  - `mis_cnt` increments on every cycle with `mispredict` = 1.
  - Both are 32-bit, wrap modulo 2^32, and are cleared by `RST`.
- `BP_STATS_EN` not defined: no counter registers are built, and `br_cnt` and `mis_cnt` are tied to 0. Prediction behaviour is identical in both builds.

## Test plan
- Cold miss after reset: assert `RST` one cycle, `if_pc` = 0x40 -> `pred_taken` = 0, `pred_target` = 0x44, `bp_stat` = `WEAK_NT`.
- Allocate on a taken branch: `upd_en` = 1, `mem_pc` = 0x40, `PC_BEQ`, `zero` = 1, `mem_target` = 0x80, `mem_pred_taken` = 0 -> `mispredict` = 1 that cycle. Next cycle `if_pc` = 0x40 gives `pred_taken` = 1, `pred_target` = 0x80, `bp_stat` = `WEAK_T`.
- Saturation and hysteresis: three more taken updates at 0x40 -> `STRONG_T`. One not-taken update (`PC_BNE`, `zero` = 1) -> `WEAK_T`, still predicts taken. A second not-taken -> `WEAK_NT`, `pred_target` = 0x44.
- Aliasing and target mismatch (`ENTRIES` = 16): taken update at 0x440 replaces the 0x40 entry, so a lookup at 0x40 misses. A taken resolution with `mem_pred_taken` = 1, `mem_pred_target` = 0x80, `mem_target` = 0x90 -> `mispredict` = 1.
- Same-cycle hazard: update 0x40 (taken) while `if_pc` = 0x40 in the same cycle -> the lookup shows the old state; the new state appears the next cycle.
- Statistics with `BP_STATS_EN`: 5 updates, 2 of them mispredicted -> `br_cnt` = 5, `mis_cnt` = 2. `RST` mid-sequence -> both 0. Without `BP_STATS_EN`, both stay 0 throughout.
